// File: rtl/pipe_stage_buf.sv
// Purpose : generic in-order pipeline stage register (control + datapath fields)
//           with valid/ready on both sides and an optional 2-entry skid buffer.
// Latency : 1 cycle from an accepted input to its presentation at the output.
// Backpr. : SKID=1 -> in_ready is driven from registers only (no out_ready path);
//           SKID=0 -> in_ready = !out_valid | out_ready (combinational).
//
// Ports
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   clr        synchronous flush: every held entry becomes a bubble at the next edge
//   in_*       upstream handshake (in_valid/in_ready) with control and data fields
//   out_*      downstream handshake (out_valid/out_ready) with head-entry fields
//   occ        number of entries held (0..2, at most 1 when SKID=0)

module pipe_stage_buf #(
    parameter int unsigned CTRL_W    = 10,
    parameter int unsigned DATA_W    = 175,
    parameter bit          SKID      = 1'b1,
    parameter bit          ZERO_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    // Occupancy-coded states: the encoding is also the value presented on occ.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d;   // main register: head entry
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [CTRL_W-1:0]   s_ctrl_q, s_ctrl_d;   // skid register: second entry
    logic [DATA_W-1:0]   s_data_q, s_data_d;
    logic                valid_q,  valid_d;
    logic                full_q,   full_d;
    logic [1:0]          occ_q,    occ_d;
    // Holds in_ready low until the first clock edge after reset release.
    logic                init_q;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = valid_q & out_ready;

    // ------------------------------------------------------------------
    // Upstream ready
    // ------------------------------------------------------------------
    generate
        if (SKID) begin : g_rdy_skid
            // Registered only: a downstream stall reaches upstream one cycle
            // later, and the skid register absorbs the entry in flight.
            assign in_ready = init_q & ~full_q;
        end else begin : g_rdy_single
            assign in_ready = init_q & (~valid_q | out_ready);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;

        if (clr) begin
            // Flush beats any transfer: a same-cycle input is dropped, a
            // same-cycle output already happened from downstream's view.
            state_d  = ST_EMPTY;
            m_ctrl_d = '0;
            s_ctrl_d = '0;
            if (ZERO_DATA) begin
                m_data_d = '0;
                s_data_d = '0;
            end
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                        state_d  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end else if (in_xfer && SKID) begin
                        // Head is stalled: park the newcomer behind it.
                        s_ctrl_d = in_ctrl;
                        s_data_d = in_data;
                        state_d  = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                        state_d  = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Flags and occupancy are registered alongside the state so that every
    // output comes straight from a flop.
    always_comb begin
        valid_d = (state_d != ST_EMPTY);
        full_d  = (state_d == ST_FULL);
        unique case (state_d)
            ST_ONE:  occ_d = 2'd1;
            ST_FULL: occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            m_ctrl_q <= '0;
            m_data_q <= '0;
            s_ctrl_q <= '0;
            s_data_q <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            occ_q    <= 2'd0;
            init_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_ctrl_q <= m_ctrl_d;
            m_data_q <= m_data_d;
            s_ctrl_q <= s_ctrl_d;
            s_data_q <= s_data_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            occ_q    <= occ_d;
            init_q   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = valid_q;
    // A bubble must decode as a NOP downstream, so control is masked while
    // nothing valid is presented; the head register may still hold a retired entry.
    assign out_ctrl  = valid_q ? m_ctrl_q : '0;
    assign out_data  = m_data_q;
    assign occ       = occ_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Two instances are exercised side by side: g_dut[0] with the skid buffer,
// g_dut[1] as a single register. Each has a queue-based reference model.
module tb_pipe_stage_buf;

    localparam int CW = 10;
    localparam int DW = 175;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    // Directed stimulus, shared by both instances while dir_en is set.
    bit            dir_en;
    bit            dir_iv;
    logic [CW-1:0] dir_c;
    logic [DW-1:0] dir_d;
    bit            dir_ordy;
    bit            dir_clr;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam bit SK = (g == 0);

        logic          in_valid;
        logic          in_ready;
        logic [CW-1:0] in_ctrl;
        logic [DW-1:0] in_data;
        logic          out_valid;
        logic          out_ready;
        logic [CW-1:0] out_ctrl;
        logic [DW-1:0] out_data;
        logic [1:0]    occ;
        logic          clr;

        ent_t q[$];          // entries the stage must still deliver, oldest first
        bit   init_m = 1'b0; // stage has seen a clock edge since reset
        bit   exp_rdy;

        pipe_stage_buf #(
            .CTRL_W   (CW),
            .DATA_W   (DW),
            .SKID     (SK),
            .ZERO_DATA(g == 0)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .in_ctrl  (in_ctrl),
            .in_data  (in_data),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_ctrl (out_ctrl),
            .out_data (out_data),
            .occ      (occ)
        );

        // Reset empties the model at once, whenever it happens.
        initial forever begin
            @(posedge rst);
            q.delete();
            init_m = 1'b0;
        end

        // Driver: issues stimulus, decides acceptance from capacity rules,
        // pushes accepted entries into the scoreboard.
        initial begin
            in_valid  = 1'b0;
            in_ctrl   = '0;
            in_data   = '0;
            out_ready = 1'b0;
            clr       = 1'b0;
            forever begin
                @(posedge clk);
                if (!rst) init_m = 1'b1;
                #2;
                if (dir_en) begin
                    in_valid  = dir_iv;
                    in_ctrl   = dir_c;
                    in_data   = dir_d;
                    out_ready = dir_ordy;
                    clr       = dir_clr;
                end else begin
                    in_valid  = ($urandom_range(0, 9) < 7);
                    in_ctrl   = CW'($urandom);
                    in_data   = rnd_data();
                    out_ready = ($urandom_range(0, 9) < 6);
                    clr       = ($urandom_range(0, 29) == 0);
                end
                #1;
                if (SK) exp_rdy = init_m && (q.size() < 2);
                else    exp_rdy = init_m && (q.size() == 0 || out_ready);
                #4;
                if (clr) begin
                    q.delete();
                end else if (in_valid && exp_rdy) begin
                    ent_t e;
                    e.c = in_ctrl;
                    e.d = in_data;
                    q.push_back(e);
                end
            end
        end

        // Monitor: checks the presented state after each edge and pops the
        // scoreboard whenever the stage hands an entry downstream.
        initial forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                chk($sformatf("out_valid[%0d]", g), 256'(out_valid), 256'(q.size() > 0));
                chk($sformatf("occ[%0d]", g), 256'(occ), 256'(q.size()));
                chk($sformatf("out_ctrl[%0d]", g), 256'(out_ctrl),
                    256'((q.size() > 0) ? q[0].c : CW'(0)));
                if (q.size() > 0)
                    chk($sformatf("out_data[%0d]", g), 256'(out_data), 256'(q[0].d));
            end
            #5;
            chk($sformatf("in_ready[%0d]", g), 256'(in_ready), 256'(exp_rdy));
            if (out_valid && out_ready) begin
                chk($sformatf("sb_nonempty[%0d]", g), 256'(q.size() > 0), 256'(1));
                if (q.size() > 0) begin
                    ent_t e;
                    e = q.pop_front();
                    chk($sformatf("pop_ctrl[%0d]", g), 256'(out_ctrl), 256'(e.c));
                    chk($sformatf("pop_data[%0d]", g), 256'(out_data), 256'(e.d));
                end
            end
        end
    end

    task automatic step(input bit iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input bit ordy, input bit cl);
        @(posedge clk);
        dir_iv   = iv;
        dir_c    = c;
        dir_d    = d;
        dir_ordy = ordy;
        dir_clr  = cl;
    endtask

    initial begin
        logic [DW-1:0] a_dat;
        rst      = 1'b1;
        dir_en   = 1'b1;
        dir_iv   = 1'b0;
        dir_c    = '0;
        dir_d    = '0;
        dir_ordy = 1'b1;
        dir_clr  = 1'b0;
        a_dat    = rnd_data();

        // Reset state
        #5;
        chk("rst_out_valid", 256'(g_dut[0].out_valid), 256'(0));
        chk("rst_out_ctrl",  256'(g_dut[0].out_ctrl),  256'(0));
        chk("rst_out_data",  256'(g_dut[0].out_data),  256'(0));
        chk("rst_occ",       256'(g_dut[0].occ),       256'(0));
        chk("rst_in_ready0", 256'(g_dut[0].in_ready),  256'(0));
        chk("rst_in_ready1", 256'(g_dut[1].in_ready),  256'(0));
        #10 rst = 1'b0;
        #1;
        chk("rel_in_ready", 256'(g_dut[0].in_ready), 256'(0));

        // 1: single entry, one cycle latency
        step(1'b1, CW'(10'h3FF), a_dat, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        #1;
        chk("t1_valid", 256'(g_dut[0].out_valid), 256'(1));
        chk("t1_ctrl",  256'(g_dut[0].out_ctrl),  256'(10'h3FF));
        chk("t1_data",  256'(g_dut[0].out_data),  256'(a_dat));
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // 2: back-to-back stream
        for (int i = 0; i < 16; i++) step(1'b1, CW'(i + 1), rnd_data(), 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);

        // 3: stall while sending A, B, C, then release
        step(1'b1, CW'(10'h0A1), rnd_data(), 1'b0, 1'b0);
        step(1'b1, CW'(10'h0B2), rnd_data(), 1'b0, 1'b0);
        step(1'b1, CW'(10'h0C3), rnd_data(), 1'b0, 1'b0);
        #1;
        chk("t3_occ0",   256'(g_dut[0].occ),      256'(2));
        chk("t3_rdy0",   256'(g_dut[0].in_ready), 256'(0));
        chk("t3_occ1",   256'(g_dut[1].occ),      256'(1));
        step(1'b1, CW'(10'h0C3), rnd_data(), 1'b0, 1'b0);
        step(1'b1, CW'(10'h0C3), rnd_data(), 1'b1, 1'b0);
        step(1'b1, CW'(10'h0C3), rnd_data(), 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);

        // 4: flush while full, with a new entry offered
        step(1'b1, CW'(10'h1E1), rnd_data(), 1'b0, 1'b0);
        step(1'b1, CW'(10'h1F2), rnd_data(), 1'b0, 1'b0);
        step(1'b1, CW'(10'h0D4), rnd_data(), 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        #1;
        chk("t4_valid", 256'(g_dut[0].out_valid), 256'(0));
        chk("t4_ctrl",  256'(g_dut[0].out_ctrl),  256'(0));
        chk("t4_occ",   256'(g_dut[0].occ),       256'(0));
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // 5: asynchronous reset while full
        step(1'b1, CW'(10'h2A5), rnd_data(), 1'b0, 1'b0);
        step(1'b1, CW'(10'h2B6), rnd_data(), 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        #11;
        chk("t5_pre_occ", 256'(g_dut[0].occ), 256'(2));
        #1 rst = 1'b1;
        #1;
        chk("t5_valid", 256'(g_dut[0].out_valid), 256'(0));
        chk("t5_ctrl",  256'(g_dut[0].out_ctrl),  256'(0));
        chk("t5_data",  256'(g_dut[0].out_data),  256'(0));
        chk("t5_occ",   256'(g_dut[0].occ),       256'(0));
        chk("t5_rdy",   256'(g_dut[0].in_ready),  256'(0));
        #2 rst = 1'b0;
        #1;
        chk("t5_rdy_rel", 256'(g_dut[0].in_ready), 256'(0));
        @(posedge clk);
        #1;
        chk("t5_rdy_edge", 256'(g_dut[0].in_ready), 256'(1));

        // Randomized traffic on both instances
        @(posedge clk);
        dir_en = 1'b0;
        repeat (3000) @(posedge clk);
        #9;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
